// File: rtl/otter_cu_fsm_mc.sv
// otter_cu_fsm_mc: multicycle OTTER control FSM with memory latency, latched interrupts, CSR/mret and illegal-opcode handling
module otter_cu_fsm_mc #(
  parameter int MEM_LAT      = 1,
  parameter int INTR_EN      = 1,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic       FSM_clk,
  input  logic       FSM_RST,
  input  logic       FSM_INTR,
  input  logic       FSM_mie,
  input  logic [6:0] FSM_opcode,
  input  logic [2:0] FSM_funct3,
  output logic       FSM_pcWrite,
  output logic       FSM_regWrite,
  output logic       FSM_memWE2,
  output logic       FSM_memRDEN1,
  output logic       FSM_memRDEN2,
  output logic       FSM_reset,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec,
  output logic       FSM_illegal,
  output logic [2:0] FSM_state
);
  typedef enum logic [2:0] {INIT, FETCH, FETCH_WAIT, EXEC, LOAD_WAIT, WB, INTR, UNUSED} state_t;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  state_t     r_ps, w_ns;
  logic [3:0] r_cnt;
  logic       r_pend;
  logic       w_alu, w_store, w_branch, w_load, w_sys, w_mret, w_csr, w_ill, w_take;
  state_t     w_done;
  assign w_alu    = FSM_opcode == 7'b0110011 || FSM_opcode == 7'b0010011 || FSM_opcode == 7'b1100111 ||
                    FSM_opcode == 7'b0110111 || FSM_opcode == 7'b0010111 || FSM_opcode == 7'b1101111;
  assign w_store  = FSM_opcode == 7'b0100011;
  assign w_branch = FSM_opcode == 7'b1100011;
  assign w_load   = FSM_opcode == 7'b0000011;
  assign w_sys    = FSM_opcode == 7'b1110011;
  assign w_mret   = w_sys && FSM_funct3 == 3'b000;
  assign w_csr    = w_sys && FSM_funct3 != 3'b000;
  assign w_ill    = !(w_alu || w_store || w_branch || w_load || w_sys);
  assign w_take   = r_pend && FSM_mie && INTR_EN != 0;
  assign w_done   = w_take ? INTR : FETCH;
  assign FSM_state = r_ps;
  always_comb begin
    w_ns         = INIT;
    FSM_pcWrite  = 1'b0;
    FSM_regWrite = 1'b0;
    FSM_memWE2   = 1'b0;
    FSM_memRDEN1 = 1'b0;
    FSM_memRDEN2 = 1'b0;
    FSM_reset    = 1'b0;
    csr_WE       = 1'b0;
    int_taken    = 1'b0;
    mret_exec    = 1'b0;
    FSM_illegal  = 1'b0;
    case (r_ps)
      INIT: begin
        FSM_reset = 1'b1;
        w_ns      = FETCH;
      end
      FETCH: begin
        FSM_memRDEN1 = 1'b1;
        w_ns         = MEM_LAT == 1 ? EXEC : FETCH_WAIT;
      end
      FETCH_WAIT: w_ns = r_cnt <= 4'd1 ? EXEC : FETCH_WAIT;
      EXEC: begin
        if (w_load) begin
          FSM_memRDEN2 = 1'b1;
          w_ns         = MEM_LAT == 1 ? WB : LOAD_WAIT;
        end else if (w_ill && ILLEGAL_TRAP == 0) begin
          FSM_illegal = 1'b1;
          FSM_reset   = 1'b1;
          w_ns        = INIT;
        end else begin
          FSM_pcWrite  = 1'b1;
          FSM_regWrite = w_alu || w_csr;
          FSM_memWE2   = w_store;
          csr_WE       = w_csr;
          mret_exec    = w_mret;
          FSM_illegal  = w_ill;
          w_ns         = w_done;
        end
      end
      LOAD_WAIT: w_ns = r_cnt <= 4'd1 ? WB : LOAD_WAIT;
      WB: begin
        FSM_pcWrite  = 1'b1;
        FSM_regWrite = 1'b1;
        w_ns         = w_done;
      end
      INTR: begin
        int_taken   = 1'b1;
        FSM_pcWrite = 1'b1;
        w_ns        = FETCH;
      end
      default: w_ns = INIT;
    endcase
  end
  // Counter idles at MEM_LAT-1 so it is already loaded on the edge entering a wait state
  always_ff @(posedge FSM_clk or posedge FSM_RST) begin
    if (FSM_RST) begin
      r_ps   <= INIT;
      r_cnt  <= 4'd0;
      r_pend <= 1'b0;
    end else begin
      r_ps   <= w_ns;
      r_cnt  <= (r_ps == FETCH_WAIT || r_ps == LOAD_WAIT) ? r_cnt - 4'd1 : LAT_M1;
      r_pend <= INTR_EN != 0 && w_ns != INTR && (r_pend || FSM_INTR);
    end
  end
endmodule

// File: tb/tb_otter_cu_fsm_mc.sv
// tb_otter_cu_fsm_mc: directed checks of the OTTER multicycle control FSM across three parameter sets
module tb_otter_cu_fsm_mc;
  localparam logic [9:0] Z  = 10'd0;
  localparam logic [9:0] PC = 10'b1000000000;
  localparam logic [9:0] RW = 10'b0100000000;
  localparam logic [9:0] WE = 10'b0010000000;
  localparam logic [9:0] R1 = 10'b0001000000;
  localparam logic [9:0] R2 = 10'b0000100000;
  localparam logic [9:0] RS = 10'b0000010000;
  localparam logic [9:0] CS = 10'b0000001000;
  localparam logic [9:0] IT = 10'b0000000100;
  localparam logic [9:0] MR = 10'b0000000010;
  localparam logic [9:0] IL = 10'b0000000001;
  logic clk = 1'b0, rst = 1'b1, intr = 1'b0, mie = 1'b0;
  logic [6:0] opc = 7'd0;
  logic [2:0] f3 = 3'd0;
  int checks = 0, failures = 0;
  logic pc3, rw3, we3, r13, r23, rs3, cs3, it3, mr3, il3;
  logic pc4, rw4, we4, r14, r24, rs4, cs4, it4, mr4, il4;
  logic pc1, rw1, we1, r11, r21, rs1, cs1, it1, mr1, il1;
  logic [2:0] st3, st4, st1;
  logic [12:0] v3, v4, v1;
  assign v3 = {st3, pc3, rw3, we3, r13, r23, rs3, cs3, it3, mr3, il3};
  assign v4 = {st4, pc4, rw4, we4, r14, r24, rs4, cs4, it4, mr4, il4};
  assign v1 = {st1, pc1, rw1, we1, r11, r21, rs1, cs1, it1, mr1, il1};
  always #5 clk = ~clk;
  otter_cu_fsm_mc #(.MEM_LAT(3), .INTR_EN(1), .ILLEGAL_TRAP(1)) d3 (
    .FSM_clk(clk), .FSM_RST(rst), .FSM_INTR(intr), .FSM_mie(mie), .FSM_opcode(opc), .FSM_funct3(f3),
    .FSM_pcWrite(pc3), .FSM_regWrite(rw3), .FSM_memWE2(we3), .FSM_memRDEN1(r13), .FSM_memRDEN2(r23),
    .FSM_reset(rs3), .csr_WE(cs3), .int_taken(it3), .mret_exec(mr3), .FSM_illegal(il3), .FSM_state(st3));
  otter_cu_fsm_mc #(.MEM_LAT(4), .INTR_EN(1), .ILLEGAL_TRAP(1)) d4 (
    .FSM_clk(clk), .FSM_RST(rst), .FSM_INTR(intr), .FSM_mie(mie), .FSM_opcode(opc), .FSM_funct3(f3),
    .FSM_pcWrite(pc4), .FSM_regWrite(rw4), .FSM_memWE2(we4), .FSM_memRDEN1(r14), .FSM_memRDEN2(r24),
    .FSM_reset(rs4), .csr_WE(cs4), .int_taken(it4), .mret_exec(mr4), .FSM_illegal(il4), .FSM_state(st4));
  otter_cu_fsm_mc #(.MEM_LAT(1), .INTR_EN(0), .ILLEGAL_TRAP(0)) d1 (
    .FSM_clk(clk), .FSM_RST(rst), .FSM_INTR(intr), .FSM_mie(mie), .FSM_opcode(opc), .FSM_funct3(f3),
    .FSM_pcWrite(pc1), .FSM_regWrite(rw1), .FSM_memWE2(we1), .FSM_memRDEN1(r11), .FSM_memRDEN2(r21),
    .FSM_reset(rs1), .csr_WE(cs1), .int_taken(it1), .mret_exec(mr1), .FSM_illegal(il1), .FSM_state(st1));
  logic [12:0] e4 [10] = '{{3'd1, R1}, {3'd2, Z}, {3'd2, Z}, {3'd2, Z}, {3'd3, R2},
                          {3'd4, Z}, {3'd4, Z}, {3'd4, Z}, {3'd5, PC | RW}, {3'd1, R1}};
  logic [12:0] e1 [10] = '{{3'd1, R1}, {3'd3, R2}, {3'd5, PC | RW}, {3'd1, R1}, {3'd3, R2},
                          {3'd5, PC | RW}, {3'd1, R1}, {3'd3, R2}, {3'd5, PC | RW}, {3'd1, R1}};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask
  // From FETCH on d3 (MEM_LAT=3): two wait cycles, EXEC check, then back to FETCH
  task automatic run3(input string tag, input logic [6:0] o, input logic [2:0] f, input logic [9:0] ctl);
    opc = o;
    f3  = f;
    tick();
    tick();
    tick();
    chk(tag, v3, {3'd3, ctl});
    tick();
    chk({tag, "_next"}, v3, {3'd1, R1});
  endtask
  initial begin
    #1;
    chk("rst_d3", v3, {3'd0, RS});
    chk("rst_d4", v4, {3'd0, RS});
    chk("rst_d1", v1, {3'd0, RS});
    tick();
    opc = 7'b0000011;
    rst = 1'b0;
    chk("init_d3", v3, {3'd0, RS});
    tick(); chk("lw3_fetch", v3, {3'd1, R1});
    tick(); chk("lw3_fw1", v3, {3'd2, Z});
    tick(); chk("lw3_fw2", v3, {3'd2, Z});
    tick(); chk("lw3_exec", v3, {3'd3, R2});
    tick(); chk("lw3_lwait", v3, {3'd4, Z});
    rst = 1'b1;
    #1;
    chk("async_rst", v3, {3'd0, RS});
    tick(); chk("rst_hold", v3, {3'd0, RS});
    rst = 1'b0;
    opc = 7'b0010011;
    chk("rel_init", v3, {3'd0, RS});
    tick(); chk("addi_fetch", v3, {3'd1, R1});
    tick(); chk("addi_fw1", v3, {3'd2, Z});
    tick(); chk("addi_fw2", v3, {3'd2, Z});
    tick(); chk("addi_exec", v3, {3'd3, PC | RW});
    tick(); chk("addi_next", v3, {3'd1, R1});
    opc = 7'b0110011;
    mie = 1'b1;
    tick();
    intr = 1'b1;
    tick();
    intr = 1'b0;
    chk("int_fw2", v3, {3'd2, Z});
    tick(); chk("int_add_exec", v3, {3'd3, PC | RW});
    tick(); chk("int_entry", v3, {3'd6, PC | IT});
    tick(); chk("int_ret_fetch", v3, {3'd1, R1});
    mie = 1'b0;
    tick();
    intr = 1'b1;
    tick();
    intr = 1'b0;
    tick(); chk("mie0_exec", v3, {3'd3, PC | RW});
    tick(); chk("mie0_no_intr", v3, {3'd1, R1});
    run3("mie0_exec2", 7'b0110011, 3'd0, PC | RW);
    mie = 1'b1;
    tick();
    tick();
    tick(); chk("pend_exec", v3, {3'd3, PC | RW});
    tick(); chk("pend_entry", v3, {3'd6, PC | IT});
    tick(); chk("pend_fetch", v3, {3'd1, R1});
    run3("csr", 7'b1110011, 3'b001, PC | RW | CS);
    run3("mret", 7'b1110011, 3'b000, PC | MR);
    run3("store", 7'b0100011, 3'b010, PC | WE);
    run3("branch", 7'b1100011, 3'b000, PC);
    run3("jal", 7'b1101111, 3'b000, PC | RW);
    run3("illegal_trap", 7'b0000000, 3'b000, PC | IL);
    opc = 7'b1110011;
    f3  = 3'b000;
    tick();
    intr = 1'b1;
    tick();
    intr = 1'b0;
    tick(); chk("b2b_mret", v3, {3'd3, PC | MR});
    tick(); chk("b2b_intr", v3, {3'd6, PC | IT});
    tick(); chk("b2b_fetch", v3, {3'd1, R1});
    rst = 1'b1;
    opc = 7'b0000011;
    mie = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("lw4_%0d", i), v4, e4[i]);
      chk($sformatf("lw1_%0d", i), v1, e1[i]);
    end
    opc = 7'b0000000;
    tick(); chk("ill_reset_exec", v1, {3'd3, IL | RS});
    tick(); chk("ill_reset_init", v1, {3'd0, RS});
    tick(); chk("ill_reset_fetch", v1, {3'd1, R1});
    opc = 7'b0010011;
    mie = 1'b1;
    intr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("noint_%0d", i), {12'd0, it1 | (st1 == 3'd6)}, 13'd0);
    end
    intr = 1'b0;
    chk("noint_exec", v1, {3'd1, R1});
    tick(); chk("noint_addi", v1, {3'd3, PC | RW});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/otter_cu_fsm_mc.md
Name: otter_cu_fsm_mc

Overview:
- Parametrised multicycle control FSM for the OTTER RV32I core.
- Sequences fetch, execute, load wait, write-back and interrupt entry.
- Adds configurable memory latency, latched interrupt handling, CSR/mret sequencing and selectable illegal-opcode handling.
- Sits between the instruction decoder/CSR file and the PC, register file and memory enables.

Parameters:
MEM_LAT, 1, memory read latency in cycles for both ports, legal range 1..15.
INTR_EN, 1, 1 = interrupt entry path present; 0 = FSM_INTR ignored and the pending latch is held at 0.
ILLEGAL_TRAP, 1, 1 = illegal opcode is skipped and flagged; 0 = illegal opcode forces a return to INIT.

Ports:
FSM_clk  in  1  system clock, rising edge.
FSM_RST  in  1  asynchronous active-high reset.
FSM_INTR  in  1  external interrupt request, level.
FSM_mie  in  1  CSR mstatus.MIE, global interrupt enable.
FSM_opcode  in  7  instruction opcode bits [6:0].
FSM_funct3  in  3  instruction funct3 bits [14:12].
FSM_pcWrite  out  1  PC register load enable.
FSM_regWrite  out  1  register file write enable.
FSM_memWE2  out  1  data port write enable.
FSM_memRDEN1  out  1  instruction port read enable.
FSM_memRDEN2  out  1  data port read enable.
FSM_reset  out  1  PC reset request.
csr_WE  out  1  CSR write enable.
int_taken  out  1  interrupt entry pulse: selects mtvec, saves mepc, clears MIE.
mret_exec  out  1  mret pulse: selects mepc, restores MIE.
FSM_illegal  out  1  one-cycle illegal-opcode flag.
FSM_state  out  3  encoded present state, for debug.

Behaviour:
- States and encoding: INIT=0, FETCH=1, FETCH_WAIT=2, EXEC=3, LOAD_WAIT=4, WB=5, INTR=6; code 7 is unused.
- All outputs are decoded combinationally from the present state and inputs. Any output not listed for a state is 0.
- Reset (async, any time, including mid-load or inside a wait state):
  - PS=INIT, wait counter=0, intr_pend=0.
  - Outputs during reset: FSM_reset=1, all other controls 0, FSM_state=0.
- Wait counter: 4 bits. Loaded with MEM_LAT-1 on entry to FETCH_WAIT or LOAD_WAIT; decrements once per cycle in those states.
- INIT: FSM_reset=1. Next state FETCH.
- FETCH: memRDEN1=1.
  - MEM_LAT=1: next state EXEC.
  - Otherwise: next state FETCH_WAIT.
- FETCH_WAIT: no enables asserted. Exit to EXEC when the counter reaches 0.
  - Total fetch-to-EXEC latency is MEM_LAT cycles.
- EXEC, decoded on FSM_opcode:
  - R-type 0110011, I-ALU 0010011, jalr 1100111, lui 0110111, auipc 0010111, jal 1101111: pcWrite=1, regWrite=1.
  - Store 0100011: pcWrite=1, memWE2=1.
  - Branch 1100011: pcWrite=1.
  - Load 0000011: memRDEN2=1, pcWrite=0, regWrite=0.
    - MEM_LAT=1: next state WB.
    - Otherwise: next state LOAD_WAIT.
  - System 1110011 with funct3=000: treated as mret. mret_exec=1, pcWrite=1.
  - System 1110011 with funct3≠000: CSR instruction. csr_WE=1, regWrite=1, pcWrite=1.
  - Any other opcode (illegal):
    - FSM_illegal=1 for the cycle.
    - ILLEGAL_TRAP=1: pcWrite=1, regWrite=0; the instruction is skipped.
    - ILLEGAL_TRAP=0: FSM_reset=1, next state INIT.
- LOAD_WAIT: no enables asserted. Exit to WB when the counter reaches 0.
- WB: pcWrite=1, regWrite=1.
- Instruction completion: the last cycle of EXEC (all non-load instructions) or WB (loads).
  - At completion: next state INTR if intr_pend & FSM_mie & INTR_EN, else FETCH.
  - The illegal opcode with ILLEGAL_TRAP=0 is the exception: it always goes to INIT.
- intr_pend register:
  - Set on any clock edge where FSM_INTR=1.
  - Cleared on the edge that enters INTR. If the set and clear conditions coincide, clear wins.
  - Not cleared by FSM_mie=0; it stays pending until enabled.
- INTR: int_taken=1 and pcWrite=1 for exactly one cycle. Next state FETCH.
- mret completion with an interrupt pending and FSM_mie=1 goes to INTR; back-to-back entry is permitted.
- Interrupts are never taken mid-instruction, including during FETCH_WAIT and LOAD_WAIT.
- Unused state code 7: all outputs 0, next state INIT.

Test Plan:
- Reset sequence: assert FSM_RST mid-LOAD_WAIT with MEM_LAT=3, release, run an addi (0010011) -> FSM_state=0 immediately, FSM_reset=1 for one cycle, then FETCH; pcWrite=1 and regWrite=1 on cycle 5 after reset release (INIT, FETCH, 2×FETCH_WAIT, EXEC).
- Load latency: MEM_LAT=1 lw -> states 1,3,5 with memRDEN2 in EXEC, regWrite in WB; MEM_LAT=4 lw -> states 1,2,2,2,3,4,4,4,5, regWrite only in WB.
- Interrupt: 1-cycle FSM_INTR pulse during FETCH_WAIT of an add with FSM_mie=1 -> add completes, then INTR with int_taken=1 and pcWrite=1 for one cycle, then FETCH; a repeat with FSM_mie=0 -> no INTR, pending held, INTR entered at the first completion after FSM_mie rises.
- CSR/mret: opcode 1110011 funct3=001 -> csr_WE=1, regWrite=1; funct3=000 -> mret_exec=1, pcWrite=1, regWrite=0.
- Illegal opcode 0000000: ILLEGAL_TRAP=1 -> FSM_illegal=1, pcWrite=1, regWrite=0, next FETCH; ILLEGAL_TRAP=0 -> FSM_illegal=1, FSM_reset=1, next INIT.
- INTR_EN=0: FSM_INTR held high for 20 cycles with FSM_mie=1 -> int_taken never asserts and INTR state is never entered.
